swc_pkt_mem_read_pump_pf: RTL and testbench
===========================================

// Module: swc_pkt_mem_read_pump_pf
// PURPOSE
//  Parametrised next-generation packet-memory read pump for the switch core. Streams one packet
//  out of the shared wide frame-buffer SRAM, one word at a time, following the page linked list.
//  Adds two lines of double-buffered read-ahead, link-list prefetch at page start and a packet abort.
//  Sits between the time-slotted MPM SRAM port / LL SRAM and one output-port consumer.
// PARAMETERS
//  g_page_addr_width  10   page address width; all-ones page address = end-of-packet marker
//  g_page_size        128  words per page (power of 2, multiple of g_ratio)
//  g_data_width       20   output word width
//  g_ratio            16   words per SRAM line (q_i = g_ratio*g_data_width bits, word 0 in LSBs)
//  g_mem_latency      2    cycles from sync cycle (addr_o sampled) to q_i valid, >=1
//  localparam LINES = g_page_size/g_ratio; MEM_AW = g_page_addr_width+log2(LINES)
// PORTS
//  clk_i        in   1          clock
//  rst_n_i      in   1          reset, asynchronous, active-low
//  pgaddr_i     in   PAW        first page of packet
//  pgreq_i      in   1          start packet at pgaddr_i (accepted only when busy_o=0)
//  abort_i      in   1          abandon current packet
//  busy_o       out  1          packet in progress (incl. abort clean-up)
//  pgend_o      out  1          1-cycle pulse: last word of a page transferred
//  pckend_o     out  1          1-cycle pulse: last word of packet transferred
//  drdy_o       out  1          d_o holds a valid word
//  dreq_i       in   1          consumer takes word; transfer = drdy_o & dreq_i
//  d_o          out  DW         output word
//  sync_i       in   1          this cycle is our SRAM slot
//  addr_o       out  MEM_AW     SRAM line address = {page, line}; sampled when sync_i=1
//  q_i          in   DW*RATIO   SRAM line data, valid g_mem_latency cycles after the issuing slot
//  ll_addr_o    out  PAW        LL read address (page whose successor is wanted)
//  ll_req_o     out  1          LL read request, held high until ll_valid_i
//  ll_valid_i   in   1          1-cycle pulse: ll_data_i valid, ends request
//  ll_data_i    in   PAW        next page or all-ones terminator
// BEHAVIOUR
//  Reset: all outputs 0, both line buffers empty, FSM IDLE; async reset mid-packet drops everything.
//  Control FSM: IDLE -pgreq_i-> RUN -(terminator known & last line issued)-> DRAIN -(last word out)-> IDLE;
//   any of RUN/DRAIN -abort_i-> ABORT -(no LL request outstanding)-> IDLE. abort_i wins over all.
//  Page start: on entering a page (pgreq or page hop), ll_req_o=1 next cycle with ll_addr_o=that page;
//   successor latched on ll_valid_i. LL never has >1 request outstanding.
//  Fetch: in a sync_i cycle, issue a line read iff a line buffer is free (counting in-flight reads)
//   and the current page still has unissued lines. Lines issued in order 0..LINES-1.
//   After line LINES-1: if successor known and != all-ones, hop page (line 0 of successor);
//   if unknown, skip slots until known; if all-ones, enter DRAIN (no further reads).
//  At most 2 lines buffered/in flight; q_i captured into the reserved buffer on its valid cycle.
//  Output: words delivered in order word0..word(RATIO-1) per line; drdy_o=1 iff head buffer holds
//   a word; d_o stable while drdy_o=1 and dreq_i=0. Freed buffer reusable from the next slot.
//  pgend_o registered: high the cycle after the transfer of word g_page_size-1 of each page;
//   pckend_o high in the same cycle for the final page; busy_o=0 from that same cycle.
//  pgreq_i while busy_o=1 ignored (no state change). pgreq_i and pckend_o same cycle: pgreq ignored.
//  Abort: next cycle drdy_o=0, buffers flushed, in-flight q_i discarded, no new reads; pgend/pckend
//   not pulsed. If LL request outstanding, ll_req_o held until ll_valid_i, data discarded; busy_o=0
//   cycle after ll_valid_i (or cycle after abort if none outstanding).
//  Page counter wraps at g_page_size-1 -> 0; line counter at LINES-1 -> 0. No arithmetic overflow
//   on page address (hop only via LL data).
// TESTING
//  Mem word k = k (line n holds n*16..n*16+15); sync every 16 cycles, LL latency 5 unless stated.
//  1 Single page: LL[2]=3FF, pgreq pg 2, dreq=1 -> d_o 256..383 in order, one pgend+pckend after 383.
//  2 Chain 2->5->8->3FF -> 384 words: 256..383, 640..767, 1024..1151; 3 pgend, 1 pckend, no dup/loss.
//  3 Case 2 with dreq random 30% duty -> identical sequence; d_o constant while dreq=0, <=2 lines ahead.
//  4 LL latency 40 cycles -> fetch stalls at page end (no addr_o change), stream resumes correctly.
//  5 Abort at word 40 with LL valid delayed 10 cycles -> drdy_o=0 next cycle, ll_req_o held to valid,
//    busy_o 0 after; then pgreq pg 7 (LL[7]=3FF) -> 896..1023, pckend once.
//  6 pgreq pg 9 during packet ignored; rst_n_i low mid-packet -> all outputs 0 immediately.

Source files
------------

// File: rtl/swc_pkt_mem_read_pump_pf.sv
// Packet-memory read pump: streams one packet out of the wide frame-buffer SRAM along the page
// linked list, with two lines of read-ahead, successor prefetch at page start and packet abort.
module swc_pkt_mem_read_pump_pf #(
    parameter int g_page_addr_width = 10,
    parameter int g_page_size       = 128,
    parameter int g_data_width      = 20,
    parameter int g_ratio           = 16,
    parameter int g_mem_latency     = 2
) (
    input  logic                                                     clk_i,
    input  logic                                                     rst_n_i,
    input  logic [g_page_addr_width-1:0]                             pgaddr_i,
    input  logic                                                     pgreq_i,
    input  logic                                                     abort_i,
    output logic                                                     busy_o,
    output logic                                                     pgend_o,
    output logic                                                     pckend_o,
    output logic                                                     drdy_o,
    input  logic                                                     dreq_i,
    output logic [g_data_width-1:0]                                  d_o,
    input  logic                                                     sync_i,
    output logic [g_page_addr_width+$clog2(g_page_size/g_ratio)-1:0] addr_o,
    input  logic [g_data_width*g_ratio-1:0]                          q_i,
    output logic [g_page_addr_width-1:0]                             ll_addr_o,
    output logic                                                     ll_req_o,
    input  logic                                                     ll_valid_i,
    input  logic [g_page_addr_width-1:0]                             ll_data_i
);
    localparam int PAW   = g_page_addr_width;
    localparam int LINES = g_page_size / g_ratio;
    localparam int LW    = $clog2(LINES);
    localparam int WW    = $clog2(g_ratio);
    localparam int QW    = g_data_width * g_ratio;
    localparam int LAT   = g_mem_latency;
    localparam logic [PAW-1:0] PG_END    = '1;
    localparam logic [LW-1:0]  LINE_LAST = LW'(LINES - 1);
    localparam logic [WW-1:0]  WORD_LAST = WW'(g_ratio - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ABORT} state_t;

    state_t           state_q, state_d;
    logic [PAW-1:0]   fpage_q, fpage_d;
    logic [LW-1:0]    fline_q, fline_d;
    logic             fdone_q, fdone_d;
    logic [PAW-1:0]   succ_q, succ_d;
    logic             succ_vld_q, succ_vld_d;
    logic             ll_req_q, ll_req_d;
    logic [PAW-1:0]   ll_addr_q, ll_addr_d;
    logic [1:0]       full_q, full_d;
    logic [1:0]       rsv_q, rsv_d;
    logic             hd_q, hd_d;
    logic             wr_q, wr_d;
    logic [WW-1:0]    widx_q, widx_d;
    logic [LW-1:0]    oline_q, oline_d;
    logic [LAT-1:0]   pipe_vld_q, pipe_vld_d;
    logic [LAT-1:0]   pipe_idx_q, pipe_idx_d;
    logic             pgend_q, pgend_d;
    logic             pckend_q, pckend_d;
    logic [QW-1:0]    buf_q [2];
    logic [QW-1:0]    buf_d [2];

    logic xfer, head_last, other_held, any_held, buf_free;
    logic issue, hop, start, finish, cap, cidx, term_known;

    assign xfer       = drdy_o & dreq_i;
    assign head_last  = xfer & (widx_q == WORD_LAST);
    assign other_held = full_q[~hd_q] | rsv_q[~hd_q];
    assign any_held   = (|full_q) | (|rsv_q);
    assign buf_free   = ~full_q[wr_q] & ~rsv_q[wr_q];
    assign term_known = fdone_q & succ_vld_q & (succ_q == PG_END);
    assign issue      = (state_q == S_RUN) & ~abort_i & sync_i & buf_free & ~fdone_q;
    assign hop        = (state_q == S_RUN) & ~abort_i & fdone_q & succ_vld_q & (succ_q != PG_END);
    assign start      = (state_q == S_IDLE) & pgreq_i & ~abort_i & ~pckend_q;
    // Packet ends on the last word of the final line, or at once if nothing is left to deliver.
    assign finish     = (state_q == S_DRAIN) & ~abort_i & ((head_last & ~other_held) | ~any_held);
    assign cap        = pipe_vld_q[LAT-1];
    assign cidx       = pipe_idx_q[LAT-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            fpage_q    <= '0;
            fline_q    <= '0;
            fdone_q    <= 1'b0;
            succ_q     <= '0;
            succ_vld_q <= 1'b0;
            ll_req_q   <= 1'b0;
            ll_addr_q  <= '0;
            full_q     <= '0;
            rsv_q      <= '0;
            hd_q       <= 1'b0;
            wr_q       <= 1'b0;
            widx_q     <= '0;
            oline_q    <= '0;
            pipe_vld_q <= '0;
            pipe_idx_q <= '0;
            pgend_q    <= 1'b0;
            pckend_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpage_q    <= fpage_d;
            fline_q    <= fline_d;
            fdone_q    <= fdone_d;
            succ_q     <= succ_d;
            succ_vld_q <= succ_vld_d;
            ll_req_q   <= ll_req_d;
            ll_addr_q  <= ll_addr_d;
            full_q     <= full_d;
            rsv_q      <= rsv_d;
            hd_q       <= hd_d;
            wr_q       <= wr_d;
            widx_q     <= widx_d;
            oline_q    <= oline_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_idx_q <= pipe_idx_d;
            pgend_q    <= pgend_d;
            pckend_q   <= pckend_d;
        end
    end

    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (abort_i)         state_d = (ll_req_q & ~ll_valid_i) ? S_ABORT : S_IDLE;
                else if (term_known) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort_i)     state_d = (ll_req_q & ~ll_valid_i) ? S_ABORT : S_IDLE;
                else if (finish) state_d = S_IDLE;
            end
            S_ABORT: if (ll_valid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fpage_d    = fpage_q;
        fline_d    = fline_q;
        fdone_d    = fdone_q;
        succ_d     = succ_q;
        succ_vld_d = succ_vld_q;
        ll_req_d   = ll_req_q;
        ll_addr_d  = ll_addr_q;
        full_d     = full_q;
        rsv_d      = rsv_q;
        hd_d       = hd_q;
        wr_d       = wr_q;
        widx_d     = widx_q;
        oline_d    = oline_q;
        buf_d      = buf_q;
        pipe_vld_d = '0;
        pipe_idx_d = '0;
        pipe_vld_d[0] = issue;
        pipe_idx_d[0] = wr_q;
        for (int i = 1; i < LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end
        pgend_d  = head_last & (oline_q == LINE_LAST) & ~abort_i;
        pckend_d = finish;

        if (ll_req_q && ll_valid_i) begin
            ll_req_d = 1'b0;
            if (state_q == S_RUN && !abort_i) begin
                succ_d     = ll_data_i;
                succ_vld_d = 1'b1;
            end
        end
        if (start || hop) begin
            fpage_d    = start ? pgaddr_i : succ_q;
            fline_d    = '0;
            fdone_d    = 1'b0;
            succ_vld_d = 1'b0;
            ll_req_d   = 1'b1;
            ll_addr_d  = start ? pgaddr_i : succ_q;
        end
        if (start) begin
            hd_d    = 1'b0;
            wr_d    = 1'b0;
            widx_d  = '0;
            oline_d = '0;
        end
        if (issue) begin
            rsv_d[wr_q] = 1'b1;
            wr_d        = ~wr_q;
            if (fline_q == LINE_LAST) fdone_d = 1'b1;
            else                      fline_d = fline_q + 1'b1;
        end
        if (cap) begin
            full_d[cidx] = 1'b1;
            rsv_d[cidx]  = 1'b0;
            buf_d[cidx]  = q_i;
        end
        if (xfer) begin
            widx_d = widx_q + 1'b1;
            if (widx_q == WORD_LAST) begin
                full_d[hd_q] = 1'b0;
                hd_d         = ~hd_q;
                oline_d      = oline_q + 1'b1;
            end
        end
        // Abort drops buffered and in-flight lines; a pending LL read is still allowed to complete.
        if (abort_i && (state_q == S_RUN || state_q == S_DRAIN)) begin
            full_d     = '0;
            rsv_d      = '0;
            pipe_vld_d = '0;
            widx_d     = '0;
        end
    end

    always_comb begin
        busy_o    = (state_q != S_IDLE);
        drdy_o    = full_q[hd_q];
        d_o       = drdy_o ? buf_q[hd_q][widx_q*g_data_width +: g_data_width] : '0;
        pgend_o   = pgend_q;
        pckend_o  = pckend_q;
        addr_o    = {fpage_q, fline_q};
        ll_addr_o = ll_addr_q;
        ll_req_o  = ll_req_q;
    end
endmodule

// File: tb/tb_swc_pkt_mem_read_pump_pf.sv
// Directed bench for swc_pkt_mem_read_pump_pf: SRAM word k holds k, LL table and latency programmable.
module tb_swc_pkt_mem_read_pump_pf;
    localparam int PAW = 10;
    localparam int DW  = 20;
    localparam int RAT = 16;
    localparam int MAW = 13;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [PAW-1:0]   pgaddr = '0;
    logic             pgreq = 1'b0;
    logic             abort = 1'b0;
    logic             busy_o, pgend_o, pckend_o, drdy_o;
    logic             dreq = 1'b0;
    logic [DW-1:0]    d_o;
    logic             sync_i = 1'b0;
    logic [MAW-1:0]   addr_o;
    logic [DW*RAT-1:0] q_i = '0;
    logic [PAW-1:0]   ll_addr_o;
    logic             ll_req_o;
    logic             ll_valid_i = 1'b0;
    logic [PAW-1:0]   ll_data_i = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PAW-1:0] ll_tab [1024];
    int  ll_lat  = 5;
    bit  ll_hold = 1'b0;
    int  ll_cnt  = 0;
    int  cyc     = 0;
    logic [MAW-1:0] a_d1 = '0, a_d2 = '0;

    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];

    swc_pkt_mem_read_pump_pf #(
        .g_page_addr_width(PAW), .g_page_size(128), .g_data_width(DW),
        .g_ratio(RAT), .g_mem_latency(2)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .pgaddr_i(pgaddr), .pgreq_i(pgreq), .abort_i(abort),
        .busy_o(busy_o), .pgend_o(pgend_o), .pckend_o(pckend_o), .drdy_o(drdy_o), .dreq_i(dreq),
        .d_o(d_o), .sync_i(sync_i), .addr_o(addr_o), .q_i(q_i), .ll_addr_o(ll_addr_o),
        .ll_req_o(ll_req_o), .ll_valid_i(ll_valid_i), .ll_data_i(ll_data_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DW*RAT-1:0] mk_line(input logic [MAW-1:0] a);
        logic [DW*RAT-1:0] l;
        int base;
        base = int'(a) * RAT;
        for (int j = 0; j < RAT; j++) l[j*DW +: DW] = DW'(base + j);
        return l;
    endfunction

    // SRAM with 2-cycle latency and a slot every 16 cycles; LL responder with programmable latency.
    always @(negedge clk) begin
        cyc = cyc + 1;
        sync_i = (cyc % 16 == 0);
        q_i  = mk_line(a_d2);
        a_d2 = a_d1;
        a_d1 = addr_o;
        if (ll_valid_i) begin
            ll_valid_i = 1'b0;
            ll_cnt = 0;
        end else if (ll_req_o && !ll_hold) begin
            ll_cnt = ll_cnt + 1;
            if (ll_cnt >= ll_lat) begin
                ll_valid_i = 1'b1;
                ll_data_i  = ll_tab[ll_addr_o];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d words", got_q.size());
        $fatal(1, "watchdog");
    end

    task automatic start_pkt(input int p);
        @(negedge clk);
        pgaddr = PAW'(p);
        pgreq  = 1'b1;
        @(negedge clk);
        pgreq  = 1'b0;
    endtask

    task automatic add_page(input int p);
        for (int w = 0; w < 128; w++) exp_q.push_back(DW'(p*128 + w));
    endtask

    // Consumes words into got_q until pckend_o, stop_words total words, or the cycle budget.
    task automatic collect(input int stop_words, input int duty, input int max_cyc,
                           output int n_pg, output int n_pk, output int stab_err,
                           output bit pg_at_end, output bit timeout);
        logic          prev_rdy, prev_req;
        logic [DW-1:0] prev_d;
        n_pg = 0; n_pk = 0; stab_err = 0; pg_at_end = 1'b0; timeout = 1'b1;
        prev_rdy = 1'b0; prev_req = 1'b0; prev_d = '0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (pgend_o) n_pg++;
            if (prev_rdy && !prev_req && (!drdy_o || d_o !== prev_d)) stab_err++;
            if (pckend_o) begin
                n_pk++;
                pg_at_end = pgend_o;
                dreq = 1'b0;
                timeout = 1'b0;
                return;
            end
            dreq = ($urandom_range(99) < duty);
            if (drdy_o && dreq) got_q.push_back(d_o);
            prev_rdy = drdy_o; prev_req = dreq; prev_d = d_o;
            if (stop_words > 0 && got_q.size() >= stop_words) begin
                timeout = 1'b0;
                return;
            end
        end
        dreq = 1'b0;
    endtask

    task automatic check_stream(input string name);
        int bad, first;
        bad = 0; first = -1;
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_len: got %0d words, expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_data: %0d bad words, first at %0d got %0d expected %0d",
                     name, bad, first, got_q[first], exp_q[first]);
        end
    endtask

    task automatic test_reset;
        logic [63:0] outs;
        repeat (3) @(negedge clk);
        outs = {busy_o, drdy_o, pgend_o, pckend_o, ll_req_o, addr_o, ll_addr_o, d_o};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0 || drdy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy %b drdy %b expected 0 0", busy_o, drdy_o);
        end
    endtask

    task automatic test_single_page;
        int n_pg, n_pk, se; bit pe, to;
        ll_tab[2] = 10'h3FF;
        got_q.delete(); exp_q.delete(); add_page(2);
        start_pkt(2);
        collect(0, 100, 3000, n_pg, n_pk, se, pe, to);
        // A new request presented in the pckend cycle must not be taken.
        pgaddr = 10'd2; pgreq = 1'b1;
        @(negedge clk);
        pgreq = 1'b0;
        n_tests++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: no pckend seen"); end
        check_stream("single");
        n_tests++;
        if (n_pg != 1 || n_pk != 1 || pe !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ends: pgend %0d pckend %0d coincident %b, expected 1 1 1", n_pg, n_pk, pe);
        end
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pgreq_at_pckend: busy %b expected 0", busy_o);
        end
    endtask

    task automatic run_chain(input string name, input int duty);
        int n_pg, n_pk, se; bit pe, to;
        ll_tab[2] = 10'd5; ll_tab[5] = 10'd8; ll_tab[8] = 10'h3FF;
        got_q.delete(); exp_q.delete(); add_page(2); add_page(5); add_page(8);
        start_pkt(2);
        collect(0, duty, 20000, n_pg, n_pk, se, pe, to);
        n_tests++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: no pckend seen", name); end
        check_stream(name);
        n_tests++;
        if (n_pg != 3 || n_pk != 1 || pe !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ends: pgend %0d pckend %0d coincident %b, expected 3 1 1", name, n_pg, n_pk, pe);
        end
        n_tests++;
        if (se != 0) begin
            n_fail++;
            $display("FAIL %s_hold: d_o/drdy_o changed without transfer %0d times, expected 0", name, se);
        end
    endtask

    task automatic test_chain;
        run_chain("chain", 100);
    endtask

    task automatic test_random_dreq;
        run_chain("rand_dreq", 30);
    endtask

    task automatic test_slow_ll;
        ll_lat = 40;
        run_chain("slow_ll", 100);
        ll_lat = 5;
    endtask

    task automatic test_abort;
        int n_pg, n_pk, se, bcyc, drop, spur; bit pe, to;
        ll_tab[2] = 10'h3FF; ll_tab[7] = 10'h3FF;
        ll_hold = 1'b1;
        got_q.delete(); exp_q.delete();
        for (int w = 0; w < 40; w++) exp_q.push_back(DW'(256 + w));
        start_pkt(2);
        collect(40, 100, 3000, n_pg, n_pk, se, pe, to);
        n_tests++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL abort_pre_timeout: got %0d words", got_q.size()); end
        check_stream("abort_pre");
        @(negedge clk);
        dreq = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if (drdy_o !== 1'b0 || ll_req_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_next: drdy %b ll_req %b busy %b expected 0 1 1", drdy_o, ll_req_o, busy_o);
        end
        ll_lat = 10; ll_hold = 1'b0;
        bcyc = 0; drop = 0; spur = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy_o) break;
            bcyc++;
            if (!ll_req_o) drop++;
            if (pgend_o || pckend_o || drdy_o) spur++;
        end
        n_tests++;
        if (bcyc < 9 || bcyc > 12) begin
            n_fail++;
            $display("FAIL abort_busy_len: busy held %0d cycles after abort, expected 9..12", bcyc);
        end
        n_tests++;
        if (drop != 0 || spur != 0 || ll_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ll: req drops %0d spurious %0d final ll_req %b, expected 0 0 0", drop, spur, ll_req_o);
        end
        ll_lat = 5;
        got_q.delete(); exp_q.delete(); add_page(7);
        start_pkt(7);
        collect(0, 100, 3000, n_pg, n_pk, se, pe, to);
        n_tests++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL abort_post_timeout: no pckend seen"); end
        check_stream("abort_post");
        n_tests++;
        if (n_pg != 1 || n_pk != 1) begin
            n_fail++;
            $display("FAIL abort_post_ends: pgend %0d pckend %0d expected 1 1", n_pg, n_pk);
        end
    endtask

    task automatic test_ignore_and_reset;
        int n_pg, n_pk, se, pg2, pk2; bit pe, to;
        logic [63:0] outs;
        ll_tab[2] = 10'd5; ll_tab[5] = 10'd8; ll_tab[8] = 10'h3FF;
        got_q.delete(); exp_q.delete(); add_page(2); add_page(5); add_page(8);
        start_pkt(2);
        collect(50, 100, 3000, n_pg, n_pk, se, pe, to);
        @(negedge clk);
        dreq = 1'b0; pgaddr = 10'd9; pgreq = 1'b1;
        @(negedge clk);
        pgreq = 1'b0;
        collect(0, 100, 5000, pg2, pk2, se, pe, to);
        check_stream("ignore_pgreq");
        n_tests++;
        if (n_pg + pg2 != 3 || n_pk + pk2 != 1) begin
            n_fail++;
            $display("FAIL ignore_ends: pgend %0d pckend %0d expected 3 1", n_pg + pg2, n_pk + pk2);
        end
        got_q.delete();
        start_pkt(2);
        collect(30, 100, 3000, n_pg, n_pk, se, pe, to);
        @(negedge clk);
        dreq = 1'b0;
        rst_n = 1'b0;
        #1;
        outs = {busy_o, drdy_o, pgend_o, pckend_o, ll_req_o, addr_o, ll_addr_o, d_o};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL async_reset: outputs %h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0 || drdy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy %b drdy %b expected 0 0", busy_o, drdy_o);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ll_tab[i] = 10'h3FF;
        test_reset;
        test_single_page;
        test_chain;
        test_random_dreq;
        test_slow_ll;
        test_abort;
        test_ignore_and_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
